// File: rtl/phase_sequencer_pkg.sv
// Shared state encodings and phase helpers for the five-phase sequencer.
// Every sequencer file imports this so the state type has a single definition.
package phase_sequencer_pkg;

   localparam int STATE_W    = 3;
   localparam int NUM_PHASES = 5;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_DECODE    = 3'd2,
      ST_EXECUTE   = 3'd3,
      ST_MEMORY    = 3'd4,
      ST_WRITEBACK = 3'd5,
      ST_HALT      = 3'd6
   } state_t;

   function automatic logic isPhaseState(input state_t s);
      return (s inside {ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEMORY, ST_WRITEBACK});
   endfunction

   // Bit 0 is fetch, bit 4 is writeback; IDLE/HALT map to all zeros.
   function automatic logic [NUM_PHASES-1:0] phaseOneHot(input state_t s);
      logic [NUM_PHASES-1:0] oh;
      oh = '0;
      case (s)
         ST_FETCH:     oh = 5'b00001;
         ST_DECODE:    oh = 5'b00010;
         ST_EXECUTE:   oh = 5'b00100;
         ST_MEMORY:    oh = 5'b01000;
         ST_WRITEBACK: oh = 5'b10000;
         default:      oh = '0;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Run control, stage handshakes and counter outputs between the sequencer and the core.
// The sequencer takes the master view; the datapath/CSR side takes the slave view.
interface phase_sequencer_if #(
   parameter int XLEN = 32
);

   logic            start;
   logic            halt_req;
   logic            stall_fetch;
   logic            stall_decode;
   logic            stall_execute;
   logic            stall_memory;
   logic            stall_writeback;
   logic            phase_fetch;
   logic            phase_decode;
   logic            phase_execute;
   logic            phase_memory;
   logic            phase_writeback;
   logic            halted;
   logic            stall_timeout;
   logic [XLEN-1:0] cycle_count;
   logic [XLEN-1:0] instret_count;

   modport master (
      input  start, halt_req,
      input  stall_fetch, stall_decode, stall_execute, stall_memory, stall_writeback,
      output phase_fetch, phase_decode, phase_execute, phase_memory, phase_writeback,
      output halted, stall_timeout, cycle_count, instret_count
   );

   modport slave (
      output start, halt_req,
      output stall_fetch, stall_decode, stall_execute, stall_memory, stall_writeback,
      input  phase_fetch, phase_decode, phase_execute, phase_memory, phase_writeback,
      input  halted, stall_timeout, cycle_count, instret_count
   );

endinterface

// File: rtl/phase_sequencer_stall_watchdog.sv
// Counts consecutive stalled cycles of the active phase and flags a trip
// on the STALL_LIMIT-th one, so a released stall can never trip.
module phase_sequencer_stall_watchdog #(
   parameter int STALL_LIMIT = 1024,
   parameter int WDT_W       = 11
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic advance_i,
   input  logic stall_i,
   output logic trip_o
);

   localparam logic [WDT_W-1:0] LAST_COUNT = WDT_W'(STALL_LIMIT - 1);

   logic [WDT_W-1:0] count_q;
   logic [WDT_W-1:0] count_d;

   assign trip_o = stall_i && !clear_i && (count_q == LAST_COUNT);

   always_comb begin
      count_d = count_q + WDT_W'(1);
      if (clear_i || advance_i || !stall_i || trip_o) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/phase_sequencer.sv
// Control FSM of the non-pipelined five-phase core: one-hot phase strobes,
// halt/run control, stall watchdog and cycle/retire performance counters.
module phase_sequencer
   import phase_sequencer_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int STALL_LIMIT = 1024,
   parameter int WDT_W       = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   phase_sequencer_if.master bus
);

   state_t                  state_q;
   state_t                  state_d;
   logic                    timeout_q;
   logic                    timeout_d;
   logic [XLEN-1:0]         cycleCnt_q;
   logic [XLEN-1:0]         cycleCnt_d;
   logic [XLEN-1:0]         instret_q;
   logic [XLEN-1:0]         instret_d;
   logic [NUM_PHASES-1:0]   phase_q;
   logic                    halted_q;
   logic                    activeStall;
   logic                    inPhase;
   logic                    advance;
   logic                    retire;
   logic                    trip;

   // Only the stall of the phase currently driven is meaningful.
   always_comb begin
      activeStall = 1'b0;
      case (state_q)
         ST_FETCH:     activeStall = bus.stall_fetch;
         ST_DECODE:    activeStall = bus.stall_decode;
         ST_EXECUTE:   activeStall = bus.stall_execute;
         ST_MEMORY:    activeStall = bus.stall_memory;
         ST_WRITEBACK: activeStall = bus.stall_writeback;
         default:      activeStall = 1'b0;
      endcase
   end

   assign inPhase = isPhaseState(state_q);
   assign advance = inPhase && !activeStall;
   assign retire  = (state_q == ST_WRITEBACK) && !bus.stall_writeback;

   phase_sequencer_stall_watchdog #(
      .STALL_LIMIT (STALL_LIMIT),
      .WDT_W       (WDT_W)
   ) u_watchdog (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (!inPhase),
      .advance_i (advance),
      .stall_i   (activeStall),
      .trip_o    (trip)
   );

   always_comb begin
      state_d    = state_q;
      timeout_d  = timeout_q || trip;
      cycleCnt_d = inPhase ? cycleCnt_q + XLEN'(1) : cycleCnt_q;
      instret_d  = retire ? instret_q + XLEN'(1) : instret_q;
      case (state_q)
         ST_IDLE:      if (bus.start) state_d = ST_FETCH;
         ST_FETCH:     if (!bus.stall_fetch) state_d = ST_DECODE;
         ST_DECODE:    if (!bus.stall_decode) state_d = ST_EXECUTE;
         ST_EXECUTE:   if (!bus.stall_execute) state_d = ST_MEMORY;
         ST_MEMORY:    if (!bus.stall_memory) state_d = ST_WRITEBACK;
         ST_WRITEBACK: if (!bus.stall_writeback) state_d = bus.halt_req ? ST_HALT : ST_FETCH;
         ST_HALT:      if (bus.start && !bus.halt_req && !timeout_q) state_d = ST_FETCH;
         default:      state_d = ST_IDLE;
      endcase
      if (trip) begin
         state_d = ST_HALT;
      end
   end

   // Strobes are loaded from the next state so they line up with state_q.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         timeout_q  <= 1'b0;
         cycleCnt_q <= '0;
         instret_q  <= '0;
         phase_q    <= '0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         timeout_q  <= timeout_d;
         cycleCnt_q <= cycleCnt_d;
         instret_q  <= instret_d;
         phase_q    <= phaseOneHot(state_d);
         halted_q   <= (state_d == ST_HALT);
      end
   end

   assign bus.phase_fetch     = phase_q[0];
   assign bus.phase_decode    = phase_q[1];
   assign bus.phase_execute   = phase_q[2];
   assign bus.phase_memory    = phase_q[3];
   assign bus.phase_writeback = phase_q[4];
   assign bus.halted          = halted_q;
   assign bus.stall_timeout   = timeout_q;
   assign bus.cycle_count     = cycleCnt_q;
   assign bus.instret_count   = instret_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed and randomized checks of phase_sequencer against an integer-based
// model of the phase sequence, halt rules, watchdog and counters.
module tb_phase_sequencer;

   localparam int TB_XLEN  = 8;
   localparam int TB_LIMIT = 8;
   localparam int TB_WDT_W = 4;
   localparam int CNT_MASK = (1 << TB_XLEN) - 1;

   logic       clk;
   logic       rstN;
   logic       startIn;
   logic       haltIn;
   logic [4:0] stallIn;

   int compareCount;
   int failCount;

   // Model: phase -1 = idle, 0..4 = fetch..writeback, 5 = halt.
   int mPhase;
   int mWdt;
   int mTimeout;
   int mCycle;
   int mInstret;

   phase_sequencer_if #(.XLEN(TB_XLEN)) bus ();

   assign bus.start           = startIn;
   assign bus.halt_req        = haltIn;
   assign bus.stall_fetch     = stallIn[0];
   assign bus.stall_decode    = stallIn[1];
   assign bus.stall_execute   = stallIn[2];
   assign bus.stall_memory    = stallIn[3];
   assign bus.stall_writeback = stallIn[4];

   phase_sequencer #(
      .XLEN        (TB_XLEN),
      .STALL_LIMIT (TB_LIMIT),
      .WDT_W       (TB_WDT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rstN),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] dutPhase();
      return {bus.phase_writeback, bus.phase_memory, bus.phase_execute,
              bus.phase_decode, bus.phase_fetch};
   endfunction

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic modelStep();
      int stalled;
      if (!rstN) begin
         mPhase = -1; mWdt = 0; mTimeout = 0; mCycle = 0; mInstret = 0;
      end else if (mPhase == -1) begin
         mWdt = 0;
         if (startIn) mPhase = 0;
      end else if (mPhase == 5) begin
         mWdt = 0;
         if (startIn && !haltIn && mTimeout == 0) mPhase = 0;
      end else begin
         mCycle = (mCycle + 1) & CNT_MASK;
         stalled = int'(stallIn[mPhase]);
         if (stalled == 0) begin
            mWdt = 0;
            if (mPhase == 4) begin
               mInstret = (mInstret + 1) & CNT_MASK;
               mPhase = haltIn ? 5 : 0;
            end else begin
               mPhase = mPhase + 1;
            end
         end else begin
            mWdt = mWdt + 1;
            if (mWdt == TB_LIMIT) begin
               mPhase = 5; mTimeout = 1; mWdt = 0;
            end
         end
      end
   endtask

   task automatic checkOutput();
      logic [4:0] expPh;
      expPh = (mPhase >= 0 && mPhase < 5) ? 5'(1 << mPhase) : 5'd0;
      check("phase", 32'(dutPhase()), 32'(expPh));
      check("halted", 32'(bus.halted), 32'(mPhase == 5));
      check("stall_timeout", 32'(bus.stall_timeout), 32'(mTimeout));
      check("cycle_count", 32'(bus.cycle_count), 32'(mCycle));
      check("instret_count", 32'(bus.instret_count), 32'(mInstret));
   endtask

   task automatic applyStimulus(input logic rst, input logic st, input logic hr, input logic [4:0] stv);
      rstN = rst; startIn = st; haltIn = hr; stallIn = stv;
   endtask

   task automatic tick();
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkOutput();
   endtask

   task automatic waitPhase(input int p);
      logic [4:0] ph;
      for (int i = 0; i < 30; i++) begin
         ph = dutPhase();
         if (ph[p]) return;
         tick();
      end
      compareCount++;
      failCount++;
      $error("[TB] FAIL wait_phase%0d observed=timeout expected=phase active", p);
   endtask

   task automatic waitHalted();
      for (int i = 0; i < 30; i++) begin
         if (bus.halted) return;
         tick();
      end
      compareCount++;
      failCount++;
      $error("[TB] FAIL wait_halted observed=timeout expected=halted");
   endtask

   initial begin
      int memHigh;
      int instretBefore;
      compareCount = 0;
      failCount = 0;
      mPhase = -1; mWdt = 0; mTimeout = 0; mCycle = 0; mInstret = 0;
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
      @(negedge clk);

      $display("[TB] reset");
      tick();
      tick();

      $display("[TB] unstalled run");
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
      for (int i = 0; i < 20; i++) tick();
      check("run20_instret", 32'(bus.instret_count), 32'd3);
      check("run20_cycles", 32'(bus.cycle_count), 32'd19);
      startIn = 1'b0;

      $display("[TB] halt request during execute");
      waitPhase(2);
      haltIn = 1'b1;
      instretBefore = mInstret;
      tick();
      waitHalted();
      check("halt_retire", 32'(bus.instret_count), 32'((instretBefore + 1) & CNT_MASK));
      haltIn = 1'b0;
      startIn = 1'b1;
      tick();
      check("restart_fetch", 32'(bus.phase_fetch), 32'd1);
      startIn = 1'b0;

      $display("[TB] memory stall of seven cycles");
      waitPhase(3);
      instretBefore = mInstret;
      stallIn = 5'b01000;
      memHigh = 1;
      for (int i = 0; i < 7; i++) begin
         tick();
         memHigh += int'(bus.phase_memory);
      end
      stallIn = 5'd0;
      tick();
      memHigh += int'(bus.phase_memory);
      check("mem_high_cycles", 32'(memHigh), 32'd8);
      waitPhase(0);
      check("mem_stall_retire", 32'(bus.instret_count), 32'((instretBefore + 1) & CNT_MASK));

      $display("[TB] watchdog on decode");
      waitPhase(1);
      stallIn = 5'b00010;
      for (int i = 0; i < TB_LIMIT - 1; i++) tick();
      check("wdt_not_yet", 32'(bus.halted), 32'd0);
      tick();
      check("wdt_halted", 32'(bus.halted), 32'd1);
      check("wdt_sticky", 32'(bus.stall_timeout), 32'd1);
      startIn = 1'b1;
      stallIn = 5'd0;
      for (int i = 0; i < 3; i++) tick();
      check("wdt_start_ignored", 32'(bus.halted), 32'd1);
      rstN = 1'b0;
      tick();
      check("wdt_reset_clears", 32'(bus.stall_timeout), 32'd0);

      $display("[TB] reset during stalled memory");
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
      waitPhase(3);
      stallIn = 5'b01000;
      tick();
      tick();
      rstN = 1'b0;
      tick();
      check("midstall_reset_phase", 32'(dutPhase()), 32'd0);
      check("midstall_reset_cycles", 32'(bus.cycle_count), 32'd0);

      $display("[TB] cycle counter wrap");
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
      for (int i = 0; i < (1 << TB_XLEN) + 1; i++) tick();
      check("cycle_wrap", 32'(bus.cycle_count), 32'd0);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 800; i++) begin
         logic [4:0] stv;
         for (int b = 0; b < 5; b++) stv[b] = ($urandom_range(0, 3) == 0);
         applyStimulus((mTimeout != 0) ? 1'b0 : ($urandom_range(0, 249) != 0),
                       $urandom_range(0, 1) == 1,
                       $urandom_range(0, 6) == 0,
                       stv);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Core control FSM for the non-pipelined five-phase RISC-V core.
- Drives one-hot phase strobes to fetch/decode/execute/memory/writeback and advances on each stage's stall_* return.
- Owns halt and run control, a stall watchdog, and cycle/retire performance counters read by the CSR unit.
- Sits beside the datapath stages; it is the source of phase_writeback and the consumer of stall_writeback.

Parameters:
- XLEN, 32, width of the performance counters.
- STALL_LIMIT, 1024, consecutive stalled cycles in one phase before the watchdog trips (≥2).
- WDT_W, 11, watchdog counter width; must hold STALL_LIMIT.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- start  in  1  level; leaves IDLE and begins fetching.
- halt_req  in  1  level; stop at the next instruction boundary.
- stall_fetch  in  1  fetch phase not finished.
- stall_decode  in  1  decode phase not finished.
- stall_execute  in  1  execute phase not finished.
- stall_memory  in  1  memory phase not finished.
- stall_writeback  in  1  writeback phase not finished.
- phase_fetch  out  1  fetch phase active.
- phase_decode  out  1  decode phase active.
- phase_execute  out  1  execute phase active.
- phase_memory  out  1  memory phase active.
- phase_writeback  out  1  writeback phase active.
- halted  out  1  FSM in HALT.
- stall_timeout  out  1  sticky watchdog error.
- cycle_count  out  XLEN  cycles spent outside IDLE/HALT.
- instret_count  out  XLEN  retired instructions.

Behaviour:
- States (encodings in package):
  - IDLE→FETCH when start=1.
  - FETCH→DECODE→EXECUTE→MEMORY→WRITEBACK, each advancing on the first cycle its own stall_*=0.
  - WRITEBACK→FETCH on completion, or →HALT if halt_req=1 on the completion cycle.
  - HALT→FETCH when start=1 and halt_req=0.
  - Any phase→HALT when the watchdog trips.
- Phase outputs:
  - Registered, one-hot, derived from state; all zero in IDLE/HALT.
  - Minimum one cycle per phase, so one unstalled instruction takes 5 cycles.
  - Only the stall_* of the active phase is sampled; the others are ignored.
- Retire: instret_count += 1 on the cycle WRITEBACK completes (phase_writeback=1, stall_writeback=0). This includes the completion cycle that enters HALT.
- cycle_count: +1 every cycle the state is a phase state (not IDLE/HALT).
- Counter widths: both counters wrap modulo 2^XLEN with no saturation.
- halt_req:
  - Never aborts a phase mid-instruction.
  - Asserted in IDLE it is ignored until after start.
  - start and halt_req both high in HALT: stay in HALT.
- Watchdog:
  - Counts consecutive cycles where the active phase's stall=1.
  - Clears on any phase advance and in IDLE/HALT.
  - When the count reaches STALL_LIMIT with stall still 1, the FSM goes to HALT next cycle and stall_timeout sets.
  - stall_timeout is cleared only by reset.
  - While stall_timeout=1, start is ignored and the FSM stays in HALT.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; all phase_* = 0; halted=0; stall_timeout=0; both counters=0; watchdog=0.
  - Takes effect from any state, including mid-phase or mid-stall.
- Simultaneous events:
  - Watchdog trip and stall release on the same cycle: the stall release wins (phase advances, no trip).
  - Writeback completion with halt_req: retire counts, then HALT.

Decomposition:
- core_general.vh: state encodings (ST_IDLE, ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEMORY, ST_WRITEBACK, ST_HALT) and the state width.
- Sub-module stall_watchdog (WDT_W counter, STALL_LIMIT compare, clear/advance inputs, trip output).
- Counters and FSM stay in phase_sequencer.

Test Plan:
- Reset, start=1, all stalls 0 for 20 cycles → phases cycle F,D,E,M,W every 5 cycles; instret_count=3 and cycle_count=19 at cycle 20 (sampled as registered outputs).
- stall_memory=1 for 7 cycles during one instruction → phase_memory high 8 cycles; that instruction takes 12 cycles; instret increments once.
- halt_req pulsed during EXECUTE, held until after WRITEBACK → WRITEBACK completes, instret increments, halted=1; start=1 with halt_req=0 → FETCH next cycle.
- STALL_LIMIT=4, stall_decode held 1 → HALT after 4 stalled cycles, stall_timeout=1; start ignored; rst_n=0 clears to IDLE.
- rst_n=0 during a stalled MEMORY phase → next cycle all phase_* = 0, counters=0, state IDLE.
- Preload cycle_count to 2^XLEN−1 (force), run 1 cycle → wraps to 0.
